timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Consumer side of the APB timer control register path.
- The APB slave writes TCR (control) and TDR (data). This block reads both every cycle and drives the 8-bit counter TCNT through a clock prescaler.
- Raises sticky overflow/underflow status flags for the status register and interrupt logic.
- Sits between the TCR/TDR register outputs and the TSR/read-back mux.

Parameters:
- DATA_WIDTH, 8, width of TCNT, TDR and TCR.
- PRE_WIDTH, 4, prescaler counter width; must hold the largest divisor minus 1 (16-1).

Ports:
- i_clk_sys  input  1  system clock, all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_tcr  input  DATA_WIDTH  TCR contents: [7]=load, [5]=count direction (0 up, 1 down), [4]=enable, [1:0]=clock select; other bits ignored.
- i_tdr  input  DATA_WIDTH  load value for TCNT.
- i_clr_ovf  input  1  one-cycle pulse, clears overflow flag.
- i_clr_udf  input  1  one-cycle pulse, clears underflow flag.
- o_tcnt  output  DATA_WIDTH  current counter value.
- o_tick  output  1  one-cycle pulse, prescaler terminal count (count event).
- o_ovf  output  1  sticky overflow flag.
- o_udf  output  1  sticky underflow flag.

Behaviour:
- Reset: on a rising edge with i_rst=1, the following are forced; reset has priority over all other events.
  - Prescaler = 0.
  - o_tcnt = 0x00.
  - o_tick = 0, o_ovf = 0, o_udf = 0.
- Divisor selection from i_tcr[1:0]:
  - 00 -> 2, 01 -> 4, 10 -> 8, 11 -> 16.
- Priority per cycle: reset > load > count > hold.
- Load (i_tcr[7]=1):
  - TCNT <= i_tdr and prescaler <= 0 on every cycle the bit is high.
  - o_tick = 0; no count and no flag set.
  - Counting resumes one full divisor period after load drops, provided enable=1.
- Hold (enable i_tcr[4]=0 and no load):
  - Prescaler and TCNT hold their values.
  - o_tick = 0; flags hold.
- Prescaler (enable=1, no load):
  - Increments each cycle.
  - When prescaler >= divisor-1: wraps to 0 and a tick occurs that cycle.
  - The >= compare guarantees a tick on the next cycle if clock select shrinks mid-count (e.g. prescaler=9, select changes to div 4).
- o_tick is registered: high in the cycle after the prescaler reaches terminal count, aligned with the TCNT update edge. Equivalently, o_tick=1 exactly in cycles where TCNT has just changed due to counting.
- Count on tick:
  - Up: TCNT+1, modulo 2^DATA_WIDTH. 0xFF -> 0x00 sets o_ovf on the same edge.
  - Down: TCNT-1. 0x00 -> 0xFF sets o_udf on the same edge.
- Direction change mid-count: takes effect on the next tick; the prescaler is not reset.
- Flags:
  - Sticky until their clear pulse.
  - Set and clear in the same cycle: set wins, flag stays 1.
  - Clear with no set: flag goes 0 on the next edge.
  - Load does not clear flags.
- Latency: TCR/TDR changes are sampled combinationally and act on the next edge; no internal pipeline beyond the single register stage.
- Reset mid-count: all state returns to reset values on that edge; TCR contents are unaffected (owned elsewhere).
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then enable up-count, div 2:
  - Stimulus: i_tcr=0x10 for 20 cycles.
  - Response: o_tick every 2nd cycle; TCNT 0x00 -> 0x0A after 20 cycles; o_ovf=0.
- Overflow wrap and flag clear:
  - Stimulus: load i_tdr=0xFE (i_tcr=0x80 for 1 cycle), then i_tcr=0x13 (div 16).
  - Response: TCNT 0xFE -> 0xFF after 16 cycles, then 0x00 after 32 with o_ovf=1.
  - Then pulse i_clr_ovf -> o_ovf=0 next cycle.
- Down-count underflow:
  - Stimulus: load 0x01, then i_tcr=0x31 (div 4).
  - Response: 0x01 -> 0x00 -> 0xFF across two ticks 4 cycles apart; o_udf=1 at the 0xFF edge; o_ovf stays 0.
- Simultaneous set and clear:
  - Stimulus: up-count at 0xFF, i_clr_ovf pulsed on the wrapping tick cycle.
  - Response: o_ovf=1 after that edge.
- Load and hold priority:
  - Stimulus: i_tcr=0x90 (load+enable) for 5 cycles with i_tdr=0x55.
  - Response: TCNT=0x55 held and o_tick=0 throughout.
  - Then i_tcr=0x00: TCNT stays 0x55 indefinitely.
- Clock-select shrink and synchronous reset:
  - Stimulus: div 16 with prescaler at 9, switch to div 4.
  - Response: tick on the next cycle.
  - Assert i_rst for 1 cycle mid-count: TCNT=0x00, prescaler=0 and all flags 0 on that edge.

Source files
------------

// File: rtl/timer_counter.sv
// Prescaled 8-bit up/down timer driven by the TCR/TDR register outputs.
// Produces TCNT, a registered count-event pulse and sticky overflow/underflow flags.
module timer_counter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRE_WIDTH  = 4
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_tcr,
  input  logic [DATA_WIDTH-1:0] i_tdr,
  input  logic                  i_clr_ovf,
  input  logic                  i_clr_udf,
  output logic [DATA_WIDTH-1:0] o_tcnt,
  output logic                  o_tick,
  output logic                  o_ovf,
  output logic                  o_udf
);

  localparam int unsigned LOAD_BIT = 7;
  localparam int unsigned DIR_BIT  = 5;
  localparam int unsigned EN_BIT   = 4;

  logic [PRE_WIDTH-1:0]  pre_q,  pre_d;
  logic [DATA_WIDTH-1:0] tcnt_q, tcnt_d;
  logic                  tick_q, tick_d;
  logic                  ovf_q,  ovf_d;
  logic                  udf_q,  udf_d;

  logic                  load, dir_down, enable;
  logic [PRE_WIDTH-1:0]  term;
  logic                  ovf_set, udf_set;
  logic                  unused_tcr;

  assign load       = i_tcr[LOAD_BIT];
  assign dir_down   = i_tcr[DIR_BIT];
  assign enable     = i_tcr[EN_BIT];
  assign unused_tcr = ^{i_tcr[DATA_WIDTH-1:0] & ~DATA_WIDTH'(8'hB3)};

  // Terminal prescaler value (divisor - 1) for the selected clock.
  always_comb begin
    term = PRE_WIDTH'(1);
    case (i_tcr[1:0])
      2'b00:   term = PRE_WIDTH'(1);
      2'b01:   term = PRE_WIDTH'(3);
      2'b10:   term = PRE_WIDTH'(7);
      default: term = PRE_WIDTH'(15);
    endcase
  end

  // Next state: load > count > hold. The >= compare forces a prompt tick
  // when the divisor shrinks below the current prescaler value.
  always_comb begin
    pre_d   = pre_q;
    tcnt_d  = tcnt_q;
    tick_d  = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (load) begin
      tcnt_d = i_tdr;
      pre_d  = '0;
    end else if (enable) begin
      if (pre_q >= term) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (dir_down) begin
          tcnt_d  = tcnt_q - DATA_WIDTH'(1);
          udf_set = (tcnt_q == '0);
        end else begin
          tcnt_d  = tcnt_q + DATA_WIDTH'(1);
          ovf_set = (tcnt_q == {DATA_WIDTH{1'b1}});
        end
      end else begin
        pre_d = pre_q + PRE_WIDTH'(1);
      end
    end
    // Set wins over a coincident clear.
    ovf_d = ovf_set | (ovf_q & ~i_clr_ovf);
    udf_d = udf_set | (udf_q & ~i_clr_udf);
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      pre_q  <= '0;
      tcnt_q <= '0;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tcnt_q <= tcnt_d;
      tick_q <= tick_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign o_tcnt = tcnt_q;
  assign o_tick = tick_q;
  assign o_ovf  = ovf_q;
  assign o_udf  = udf_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus queues cycle-stamped expected
// outputs, a monitor on the falling edge pops and compares them.
module tb_timer_counter;

  logic       clk;
  logic       rst;
  logic [7:0] tcr;
  logic [7:0] tdr;
  logic       clr_ovf;
  logic       clr_udf;
  logic [7:0] tcnt;
  logic       tick;
  logic       ovf;
  logic       udf;

  typedef struct {
    int         cyc;
    logic [7:0] tcnt;
    logic       tick;
    logic       ovf;
    logic       udf;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  timer_counter #(.DATA_WIDTH(8), .PRE_WIDTH(4)) dut (
    .i_clk_sys (clk),
    .i_rst     (rst),
    .i_tcr     (tcr),
    .i_tdr     (tdr),
    .i_clr_ovf (clr_ovf),
    .i_clr_udf (clr_udf),
    .o_tcnt    (tcnt),
    .o_tick    (tick),
    .o_ovf     (ovf),
    .o_udf     (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expectation for the outputs visible dc rising edges from now.
  task automatic expect_at(input int dc, input logic [7:0] t, input logic tk,
                           input logic o, input logic u, input string nm);
    exp_t e;
    e.cyc = cyc + dc; e.tcnt = t; e.tick = tk; e.ovf = o; e.udf = u; e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if (tcnt !== e.tcnt || tick !== e.tick || ovf !== e.ovf || udf !== e.udf) begin
        errors++;
        $display("FAIL %s @cyc %0d: got tcnt=%h tick=%b ovf=%b udf=%b, want tcnt=%h tick=%b ovf=%b udf=%b",
                 e.name, cyc, tcnt, tick, ovf, udf, e.tcnt, e.tick, e.ovf, e.udf);
      end
    end
  end

  initial begin
    rst = 1'b1; tcr = 8'h00; tdr = 8'h00; clr_ovf = 1'b0; clr_udf = 1'b0;
    step(1);
    expect_at(1, 8'h00, 1'b0, 1'b0, 1'b0, "reset");
    step(1);

    // Up count, divide by 2.
    rst = 1'b0; tcr = 8'h10;
    for (int k = 1; k <= 20; k++)
      expect_at(k, 8'(k / 2), (k % 2) == 0, 1'b0, 1'b0, "up_div2");
    step(20);

    // Overflow at divide by 16, then clear.
    tdr = 8'hFE; tcr = 8'h80;
    expect_at(1, 8'hFE, 1'b0, 1'b0, 1'b0, "load_fe");
    step(1);
    tcr = 8'h13;
    expect_at(15, 8'hFE, 1'b0, 1'b0, 1'b0, "div16_wait");
    expect_at(16, 8'hFF, 1'b1, 1'b0, 1'b0, "div16_tick1");
    expect_at(17, 8'hFF, 1'b0, 1'b0, 1'b0, "div16_after1");
    expect_at(32, 8'h00, 1'b1, 1'b1, 1'b0, "ovf_wrap");
    expect_at(33, 8'h00, 1'b0, 1'b1, 1'b0, "ovf_sticky");
    step(33);
    tcr = 8'h00; clr_ovf = 1'b1;
    expect_at(1, 8'h00, 1'b0, 1'b0, 1'b0, "ovf_clear");
    step(1);
    clr_ovf = 1'b0;

    // Down count underflow, divide by 4.
    tdr = 8'h01; tcr = 8'h80;
    expect_at(1, 8'h01, 1'b0, 1'b0, 1'b0, "load_01");
    step(1);
    tcr = 8'h31;
    expect_at(3, 8'h01, 1'b0, 1'b0, 1'b0, "div4_wait");
    expect_at(4, 8'h00, 1'b1, 1'b0, 1'b0, "down_to_00");
    expect_at(5, 8'h00, 1'b0, 1'b0, 1'b0, "down_hold");
    expect_at(8, 8'hFF, 1'b1, 1'b0, 1'b1, "udf_wrap");
    expect_at(9, 8'hFF, 1'b0, 1'b0, 1'b1, "udf_sticky");
    step(9);
    tcr = 8'h00; clr_udf = 1'b1;
    expect_at(1, 8'hFF, 1'b0, 1'b0, 1'b0, "udf_clear");
    step(1);
    clr_udf = 1'b0;

    // Set and clear of overflow in the same cycle: set wins.
    tdr = 8'hFF; tcr = 8'h80;
    expect_at(1, 8'hFF, 1'b0, 1'b0, 1'b0, "load_ff");
    step(1);
    tcr = 8'h10;
    expect_at(1, 8'hFF, 1'b0, 1'b0, 1'b0, "pre_wrap");
    step(1);
    clr_ovf = 1'b1;
    expect_at(1, 8'h00, 1'b1, 1'b1, 1'b0, "set_beats_clr");
    step(1);
    clr_ovf = 1'b0; tcr = 8'h00;
    expect_at(1, 8'h00, 1'b0, 1'b1, 1'b0, "ovf_held");
    step(1);
    clr_ovf = 1'b1;
    expect_at(1, 8'h00, 1'b0, 1'b0, 1'b0, "ovf_clear2");
    step(1);
    clr_ovf = 1'b0;

    // Load has priority over enable, then hold keeps the value.
    tdr = 8'h55; tcr = 8'h90;
    for (int k = 1; k <= 5; k++)
      expect_at(k, 8'h55, 1'b0, 1'b0, 1'b0, "load_en");
    step(5);
    tcr = 8'h00; tdr = 8'hAA;
    for (int k = 1; k <= 10; k++)
      expect_at(k, 8'h55, 1'b0, 1'b0, 1'b0, "hold");
    step(10);

    // Clock-select shrink with prescaler at 9, then reset mid-count.
    tdr = 8'h00; tcr = 8'h80;
    expect_at(1, 8'h00, 1'b0, 1'b0, 1'b0, "load_00");
    step(1);
    tcr = 8'h33;
    expect_at(9, 8'h00, 1'b0, 1'b0, 1'b0, "pre_at_9");
    step(9);
    tcr = 8'h31;
    expect_at(1, 8'hFF, 1'b1, 1'b0, 1'b1, "shrink_tick");
    step(1);
    expect_at(1, 8'hFF, 1'b0, 1'b0, 1'b1, "after_shrink");
    step(1);
    rst = 1'b1;
    expect_at(1, 8'h00, 1'b0, 1'b0, 1'b0, "mid_reset");
    step(1);
    rst = 1'b0;
    expect_at(3, 8'h00, 1'b0, 1'b0, 1'b0, "post_reset_wait");
    expect_at(4, 8'hFF, 1'b1, 1'b0, 1'b1, "post_reset_tick");
    step(4);

    step(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
